// File: rtl/recovery_checkpoint_ctrl.sv
// Checkpoint/rollback sequencer between the voted core register file and the
// recovery register file of the TMR core; stalls the pipeline while active.
module recovery_checkpoint_ctrl #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_in,
  input  logic            ckpt_req,
  input  logic            err_req,
  input  logic [DW-1:0]   ckpt_pc,
  output logic [4:0]      core_rd_addr,
  input  logic [DW-1:0]   core_rd_data,
  output logic            rr_we,
  output logic [31:0]     rr_addr,
  output logic [DW-1:0]   rr_wd,
  input  logic [DW-1:0]   rr_rd,
  output logic            core_we,
  output logic [4:0]      core_wr_addr,
  output logic [DW-1:0]   core_wd,
  output logic            stall,
  output logic            ckpt_done,
  output logic            restore_done,
  output logic [DW-1:0]   restore_pc,
  output logic            ckpt_valid,
  output logic            err_unrecov,
  output logic [CNTW-1:0] err_cnt
);
  typedef enum logic [1:0] {IDLE = 2'd0, SAVE = 2'd1, RESTORE = 2'd2, DONE = 2'd3} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NREG - 1);

  state_t        state, state_nx;
  logic [4:0]    idx, idx_nx;
  logic          kind_rst, kind_rst_nx;  // DONE follows a restore rather than a save
  logic [DW-1:0] pc_q;
  logic          accept_ckpt, set_valid, set_unrecov, inc_cnt;

  // sequencer state register
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state    <= IDLE;
      idx      <= 5'd0;
      kind_rst <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      kind_rst <= kind_rst_nx;
    end
  end

  // checkpoint bookkeeping: saved PC, validity, sticky error, restore count
  always_ff @(posedge clk) begin
    if (rst_in) begin
      pc_q        <= '0;
      ckpt_valid  <= 1'b0;
      err_unrecov <= 1'b0;
      err_cnt     <= '0;
    end else begin
      if (accept_ckpt) begin
        pc_q       <= ckpt_pc;
        ckpt_valid <= 1'b0;
      end else if (set_valid) begin
        ckpt_valid <= 1'b1;
      end
      if (set_unrecov) err_unrecov <= 1'b1;
      if (inc_cnt && (err_cnt != {CNTW{1'b1}})) err_cnt <= err_cnt + CNTW'(1);
    end
  end

  assign restore_pc = pc_q;
  assign stall      = (state != IDLE);

  // next-state and per-state datapath steering
  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    kind_rst_nx  = kind_rst;
    accept_ckpt  = 1'b0;
    set_valid    = 1'b0;
    set_unrecov  = 1'b0;
    inc_cnt      = 1'b0;
    core_rd_addr = 5'd0;
    rr_we        = 1'b0;
    rr_addr      = 32'd0;
    rr_wd        = '0;
    core_we      = 1'b0;
    core_wr_addr = 5'd0;
    core_wd      = '0;
    ckpt_done    = 1'b0;
    restore_done = 1'b0;
    case (state)
      IDLE: begin
        if (err_req) begin
          if (ckpt_valid) begin
            state_nx    = RESTORE;
            idx_nx      = 5'd0;
            kind_rst_nx = 1'b1;
          end else begin
            set_unrecov = 1'b1;
          end
        end else if (ckpt_req) begin
          accept_ckpt = 1'b1;
          state_nx    = SAVE;
          idx_nx      = 5'd0;
          kind_rst_nx = 1'b0;
        end else begin
          state_nx = IDLE;
        end
      end
      SAVE: begin
        core_rd_addr = idx;
        rr_addr      = {27'd0, idx};
        rr_wd        = core_rd_data;
        // an error mid-save leaves a torn checkpoint that must never be replayed
        if (err_req) begin
          set_unrecov = 1'b1;
          state_nx    = IDLE;
          idx_nx      = 5'd0;
        end else begin
          rr_we = 1'b1;
          if (idx == LAST_IDX) begin
            set_valid = 1'b1;
            state_nx  = DONE;
            idx_nx    = 5'd0;
          end else begin
            idx_nx = idx + 5'd1;
          end
        end
      end
      RESTORE: begin
        rr_addr      = {27'd0, idx};
        core_wr_addr = idx;
        core_wd      = rr_rd;
        core_we      = (idx != 5'd0);
        if (idx == LAST_IDX) begin
          inc_cnt  = 1'b1;
          state_nx = DONE;
          idx_nx   = 5'd0;
        end else begin
          idx_nx = idx + 5'd1;
        end
      end
      DONE: begin
        ckpt_done    = ~kind_rst;
        restore_done = kind_rst;
        state_nx     = IDLE;
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = 5'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_recovery_checkpoint_ctrl.sv
// Self-checking bench for recovery_checkpoint_ctrl: randomized register data and
// PCs checked against a snapshot/replay reference model of checkpoint semantics.
module tb_recovery_checkpoint_ctrl;
  localparam int NREG = 32;
  localparam int DW   = 32;
  localparam int CNTW = 8;

  logic            clk = 1'b0;
  logic            rst_in, ckpt_req, err_req;
  logic [DW-1:0]   ckpt_pc, core_rd_data, rr_wd, rr_rd, core_wd, restore_pc;
  logic [4:0]      core_rd_addr, core_wr_addr;
  logic            rr_we, core_we, stall, ckpt_done, restore_done, ckpt_valid, err_unrecov;
  logic [31:0]     rr_addr;
  logic [CNTW-1:0] err_cnt;

  logic [DW-1:0] core_rf [NREG];
  logic [DW-1:0] rr_mem  [NREG];
  int total = 0, bad = 0;
  int rr_wr_n = 0, core_wr_n = 0, x0_wr_n = 0, rr_hi_n = 0;

  // reference model: what a checkpoint holds and what a rollback must produce
  logic [DW-1:0] m_snap [NREG];
  logic [DW-1:0] m_pc;
  bit            m_valid, m_unrecov;
  int            m_cnt;

  recovery_checkpoint_ctrl #(.NREG(NREG), .DW(DW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_in(rst_in), .ckpt_req(ckpt_req), .err_req(err_req), .ckpt_pc(ckpt_pc),
    .core_rd_addr(core_rd_addr), .core_rd_data(core_rd_data), .rr_we(rr_we), .rr_addr(rr_addr),
    .rr_wd(rr_wd), .rr_rd(rr_rd), .core_we(core_we), .core_wr_addr(core_wr_addr),
    .core_wd(core_wd), .stall(stall), .ckpt_done(ckpt_done), .restore_done(restore_done),
    .restore_pc(restore_pc), .ckpt_valid(ckpt_valid), .err_unrecov(err_unrecov), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  assign core_rd_data = core_rf[core_rd_addr];
  assign rr_rd        = rr_mem[rr_addr[4:0]];

  // One clock: settle, latch write strobes, apply them at the edge, resume 1 after it.
  task automatic tick();
    logic w_rr, w_core;
    logic [4:0] a_rr, a_core;
    logic [DW-1:0] d_rr, d_core;
    #1;
    w_rr = rr_we; a_rr = rr_addr[4:0]; d_rr = rr_wd;
    w_core = core_we; a_core = core_wr_addr; d_core = core_wd;
    if (w_rr && rr_addr[31:5] != 27'd0) rr_hi_n++;
    @(posedge clk);
    if (w_rr) begin rr_mem[a_rr] = d_rr; rr_wr_n++; end
    if (w_core) begin core_rf[a_core] = d_core; core_wr_n++; if (a_core == 5'd0) x0_wr_n++; end
    #1;
  endtask

  task automatic model_ckpt(input logic [DW-1:0] pc);
    for (int i = 0; i < NREG; i++) m_snap[i] = core_rf[i];
    m_pc = pc; m_valid = 1'b1;
  endtask

  task automatic model_err();
    if (m_valid) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    else m_unrecov = 1'b1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1; ckpt_req = 1'b0; err_req = 1'b0;
    tick(); tick();
    rst_in = 1'b0;
    m_valid = 1'b0; m_unrecov = 1'b0; m_cnt = 0; m_pc = '0;
  endtask

  // Accept edge, then follow the sequence until stall drops (bounded).
  task automatic run_seq(input bit is_ckpt, output int done_at, output int stall_n, output int wrong_n);
    done_at = 0; stall_n = 0; wrong_n = 0;
    tick();
    ckpt_req = 1'b0; err_req = 1'b0;
    for (int n = 1; n <= NREG + 8; n++) begin
      #1;
      if (stall) stall_n++;
      if ((is_ckpt ? ckpt_done : restore_done) && done_at == 0) done_at = n;
      if (is_ckpt ? restore_done : ckpt_done) wrong_n++;
      if (!stall) break;
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({stall, rr_we, core_we, ckpt_done, restore_done, ckpt_valid, err_unrecov} !== 7'd0) begin
      bad++; $display("FAIL reset_flags got=%b want=0", {stall, rr_we, core_we, ckpt_done, restore_done, ckpt_valid, err_unrecov}); end
    total++; if ({err_cnt, restore_pc} !== {CNTW'(0), 32'd0}) begin
      bad++; $display("FAIL reset_cnt_pc got=%0h/%0h want=0/0", err_cnt, restore_pc); end
  endtask

  task automatic test_unrecov_no_ckpt();
    do_reset();
    rr_wr_n = 0; core_wr_n = 0;
    err_req = 1'b1; model_err(); tick(); err_req = 1'b0;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL unrec_stall got=%0b want=0", stall); end
    total++; if (err_unrecov !== m_unrecov) begin bad++; $display("FAIL unrec_flag got=%0b want=%0b", err_unrecov, m_unrecov); end
    tick(); tick();
    total++; if (rr_wr_n + core_wr_n != 0) begin bad++; $display("FAIL unrec_writes got=%0d want=0", rr_wr_n + core_wr_n); end
  endtask

  task automatic test_checkpoint(input logic [DW-1:0] pc, input bit rnd);
    int done_at, stall_n, wrong_n, mism;
    for (int i = 0; i < NREG; i++) core_rf[i] = rnd ? DW'($urandom) : DW'(i * 3);
    rr_wr_n = 0; rr_hi_n = 0;
    ckpt_pc = pc; ckpt_req = 1'b1; model_ckpt(pc);
    run_seq(1'b1, done_at, stall_n, wrong_n);
    mism = 0;
    for (int i = 0; i < NREG; i++) if (rr_mem[i] !== m_snap[i]) mism++;
    total++; if (done_at != NREG + 1) begin bad++; $display("FAIL ckpt_done_cycle got=%0d want=%0d", done_at, NREG + 1); end
    total++; if (stall_n != NREG + 1 || wrong_n != 0) begin bad++; $display("FAIL ckpt_stall got=%0d/%0d want=%0d/0", stall_n, wrong_n, NREG + 1); end
    total++; if (rr_wr_n != NREG || rr_hi_n != 0) begin bad++; $display("FAIL ckpt_writes got=%0d/%0d want=%0d/0", rr_wr_n, rr_hi_n, NREG); end
    total++; if (mism != 0) begin bad++; $display("FAIL ckpt_data got=%0d bad entries want=0", mism); end
    total++; if (ckpt_valid !== m_valid || restore_pc !== m_pc) begin
      bad++; $display("FAIL ckpt_state got=%0b/%0h want=%0b/%0h", ckpt_valid, restore_pc, m_valid, m_pc); end
  endtask

  task automatic test_restore();
    int done_at, stall_n, wrong_n, mism;
    logic [DW-1:0] x0;
    for (int i = 0; i < NREG; i++) core_rf[i] = DW'($urandom);
    x0 = core_rf[0];
    core_wr_n = 0; x0_wr_n = 0;
    err_req = 1'b1; model_err();
    run_seq(1'b0, done_at, stall_n, wrong_n);
    mism = 0;
    for (int i = 1; i < NREG; i++) if (core_rf[i] !== m_snap[i]) mism++;
    total++; if (done_at != NREG + 1 || stall_n != NREG + 1 || wrong_n != 0) begin
      bad++; $display("FAIL rest_timing got=%0d/%0d/%0d want=%0d/%0d/0", done_at, stall_n, wrong_n, NREG + 1, NREG + 1); end
    total++; if (core_wr_n != NREG - 1 || x0_wr_n != 0 || core_rf[0] !== x0) begin
      bad++; $display("FAIL rest_writes got=%0d/%0d want=%0d/0", core_wr_n, x0_wr_n, NREG - 1); end
    total++; if (mism != 0) begin bad++; $display("FAIL rest_data got=%0d bad regs want=0", mism); end
    total++; if (err_cnt !== CNTW'(m_cnt) || ckpt_valid !== 1'b1 || restore_pc !== m_pc) begin
      bad++; $display("FAIL rest_state got=%0d/%0b/%0h want=%0d/1/%0h", err_cnt, ckpt_valid, restore_pc, m_cnt, m_pc); end
  endtask

  task automatic test_save_abort();
    int dones;
    logic we_at_err;
    do_reset();
    for (int i = 0; i < NREG; i++) core_rf[i] = DW'(i * 3);
    rr_wr_n = 0; dones = 0;
    ckpt_pc = 32'h200; ckpt_req = 1'b1; tick(); ckpt_req = 1'b0;
    m_pc = 32'h200;
    for (int n = 1; n <= 10; n++) begin if (ckpt_done) dones++; tick(); end
    err_req = 1'b1; #1; we_at_err = rr_we;
    tick(); err_req = 1'b0;
    m_valid = 1'b0; m_unrecov = 1'b1;
    for (int n = 0; n < 40; n++) begin if (ckpt_done) dones++; tick(); end
    total++; if (rr_wr_n != 10 || we_at_err !== 1'b0) begin bad++; $display("FAIL abort_writes got=%0d/%0b want=10/0", rr_wr_n, we_at_err); end
    total++; if (ckpt_valid !== m_valid || err_unrecov !== m_unrecov || dones != 0 || stall !== 1'b0) begin
      bad++; $display("FAIL abort_state got=%0b/%0b/%0d/%0b want=0/1/0/0", ckpt_valid, err_unrecov, dones, stall); end
    core_wr_n = 0;
    err_req = 1'b1; model_err(); tick(); err_req = 1'b0;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL abort_norestore_stall got=%0b want=0", stall); end
    for (int n = 0; n < 5; n++) tick();
    total++; if (core_wr_n != 0 || err_cnt !== CNTW'(m_cnt)) begin
      bad++; $display("FAIL abort_norestore got=%0d/%0d want=0/%0d", core_wr_n, err_cnt, m_cnt); end
  endtask

  task automatic test_both_requests();
    int n, rd_at, mism;
    logic [DW-1:0] pc_b;
    do_reset();
    test_checkpoint(32'h1000 + DW'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < NREG; i++) core_rf[i] = DW'($urandom);
    pc_b = DW'($urandom);
    core_wr_n = 0; rd_at = 0;
    ckpt_pc = pc_b; ckpt_req = 1'b1; err_req = 1'b1; model_err();
    tick(); err_req = 1'b0;
    for (n = 1; n <= NREG + 4 && rd_at == 0; n++) begin #1; if (restore_done) rd_at = n; tick(); end
    total++; if (rd_at != NREG + 1 || core_wr_n != NREG - 1) begin
      bad++; $display("FAIL both_restore got=%0d/%0d want=%0d/%0d", rd_at, core_wr_n, NREG + 1, NREG - 1); end
    total++; if (stall !== 1'b0 || restore_pc !== m_pc) begin
      bad++; $display("FAIL both_pc_kept got=%0b/%0h want=0/%0h", stall, restore_pc, m_pc); end
    model_ckpt(pc_b);
    rr_wr_n = 0;
    tick();
    total++; if (stall !== 1'b1 || rr_we !== 1'b1) begin bad++; $display("FAIL both_resave got=%0b/%0b want=1/1", stall, rr_we); end
    ckpt_req = 1'b0;
    for (int j = 0; j < NREG + 8 && stall; j++) tick();
    mism = 0;
    for (int i = 0; i < NREG; i++) if (rr_mem[i] !== m_snap[i]) mism++;
    total++; if (ckpt_valid !== 1'b1 || restore_pc !== pc_b || mism != 0 || rr_wr_n != NREG) begin
      bad++; $display("FAIL both_resave_done got=%0b/%0h/%0d/%0d want=1/%0h/0/%0d", ckpt_valid, restore_pc, mism, rr_wr_n, pc_b, NREG); end
  endtask

  task automatic test_reset_mid_restore();
    test_checkpoint(DW'($urandom), 1'b1);
    err_req = 1'b1; tick(); err_req = 1'b0;
    for (int n = 1; n <= 20; n++) tick();
    total++; if (stall !== 1'b1 || core_wr_addr !== 5'd20) begin bad++; $display("FAIL midrst_pos got=%0b/%0d want=1/20", stall, core_wr_addr); end
    rst_in = 1'b1; tick();
    total++; if ({stall, rr_we, core_we, ckpt_done, restore_done, ckpt_valid, err_unrecov} !== 7'd0) begin
      bad++; $display("FAIL midrst_flags got=%b want=0", {stall, rr_we, core_we, ckpt_done, restore_done, ckpt_valid, err_unrecov}); end
    total++; if ({err_cnt, restore_pc, core_rd_addr, rr_addr, rr_wd, core_wr_addr, core_wd} !== '0) begin
      bad++; $display("FAIL midrst_buses got=%0h/%0h/%0h/%0h want=0", err_cnt, restore_pc, rr_addr, core_wd); end
    rst_in = 1'b0;
    m_valid = 1'b0; m_unrecov = 1'b0; m_cnt = 0; m_pc = '0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      test_checkpoint(DW'($urandom), 1'b1);
      for (int r = 0; r < int'($urandom_range(1, 2)); r++) test_restore();
    end
  endtask

  task automatic test_saturate();
    do_reset();
    test_checkpoint(DW'($urandom), 1'b1);
    for (int r = 0; r < 256; r++) begin
      err_req = 1'b1; model_err(); tick(); err_req = 1'b0;
      for (int j = 0; j < NREG + 8 && stall; j++) tick();
      if (r == 99) begin
        total++; if (err_cnt !== CNTW'(m_cnt)) begin bad++; $display("FAIL sat_mid got=%0d want=%0d", err_cnt, m_cnt); end
      end
    end
    total++; if (err_cnt !== CNTW'(m_cnt)) begin bad++; $display("FAIL sat_final got=%0d want=%0d", err_cnt, m_cnt); end
  endtask

  initial begin
    rst_in = 1'b1; ckpt_req = 1'b0; err_req = 1'b0; ckpt_pc = '0;
    for (int i = 0; i < NREG; i++) begin core_rf[i] = '0; rr_mem[i] = '0; end
    test_reset();
    test_unrecov_no_ckpt();
    do_reset();
    test_checkpoint(32'h100, 1'b0);
    test_restore();
    test_save_abort();
    test_both_requests();
    test_reset_mid_restore();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
